// File: rtl/dac_spi_driver.sv
// 16-bit SPI frame driver for a 12-bit DAC: sync_n framed, sclk idle high, MSB first.
// Build option DAC_MV_SCALE_EN: convert a millivolt sample to a DAC code instead of passing it through.
`ifndef DAC_MAX_V_BIT
`define DAC_MAX_V_BIT 13
`endif
`ifndef DAC_MAX_V
`define DAC_MAX_V 3300
`endif

module dac_spi_driver #(
    parameter int CLK_DIV    = 2,
    parameter int GAP_CYCLES = 2
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [`DAC_MAX_V_BIT-1:0] sample_in,
    input  logic                      sample_valid,
    output logic                      ready,
    output logic                      dropped,
    output logic                      done,
    output logic                      sclk,
    output logic                      sync_n,
    output logic                      sdata
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        SHIFT = 2'd2,
        GAP   = 2'd3
    } state_t;

    localparam int         SW       = `DAC_MAX_V_BIT;
    localparam logic [7:0] DIV_LAST = 8'(CLK_DIV - 1);
    localparam logic [7:0] GAP_LAST = 8'(GAP_CYCLES - 1);

    state_t      state_r, state_nxt_s;
    logic [11:0] code_s, code_r;
    logic [15:0] frame_s;
    logic [14:0] shift_r;
    logic [7:0]  div_cnt_r, gap_cnt_r;
    logic [4:0]  half_cnt_r;
    logic        ready_r, dropped_r, done_r, sclk_r, sync_n_r, sdata_r;
    logic        ready_nxt_s, dropped_nxt_s, done_nxt_s, sclk_nxt_s, sync_n_nxt_s, sdata_nxt_s;
    logic        accept_s, div_end_s, shift_end_s, gap_end_s, rise_s;

`ifdef DAC_MV_SCALE_EN
    localparam int PW = SW + 12;
    logic [SW-1:0] clamp_s;

    // Millivolts to code: clamp to full scale, then scale by 4095/full-scale with truncation
    always_comb begin
        if (sample_in > SW'(`DAC_MAX_V)) begin
            clamp_s = SW'(`DAC_MAX_V);
        end else begin
            clamp_s = sample_in;
        end
        code_s = 12'((PW'(clamp_s) * PW'(12'd4095)) / PW'(`DAC_MAX_V));
    end
`else
    // Raw code passthrough, saturated to the 12-bit range
    always_comb begin
        if (sample_in > SW'(12'hFFF)) begin
            code_s = 12'hFFF;
        end else begin
            code_s = sample_in[11:0];
        end
    end
`endif

    assign frame_s     = {4'b0000, code_r};
    assign accept_s    = sample_valid && ready_r;
    assign div_end_s   = (div_cnt_r == DIV_LAST);
    assign shift_end_s = (state_r == SHIFT) && div_end_s && (half_cnt_r == 5'd31);
    assign gap_end_s   = (state_r == GAP) && (gap_cnt_r == GAP_LAST);
    assign rise_s      = (state_r == SHIFT) && div_end_s && !sclk_r;

    // State register
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Next-state logic
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            IDLE: begin
                if (accept_s) begin
                    state_nxt_s = LOAD;
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            LOAD: state_nxt_s = SHIFT;
            SHIFT: begin
                if (shift_end_s) begin
                    state_nxt_s = GAP;
                end else begin
                    state_nxt_s = SHIFT;
                end
            end
            GAP: begin
                if (gap_end_s) begin
                    state_nxt_s = IDLE;
                end else begin
                    state_nxt_s = GAP;
                end
            end
            default: state_nxt_s = IDLE;
        endcase
    end

    // Next values of the registered outputs; the final half-period ends with sclk high and done
    always_comb begin
        sclk_nxt_s    = 1'b1;
        sync_n_nxt_s  = 1'b1;
        sdata_nxt_s   = 1'b0;
        done_nxt_s    = 1'b0;
        dropped_nxt_s = sample_valid && !ready_r;
        ready_nxt_s   = (state_nxt_s == IDLE);
        case (state_r)
            LOAD: begin
                sync_n_nxt_s = 1'b0;
                sdata_nxt_s  = frame_s[15];
            end
            SHIFT: begin
                if (shift_end_s) begin
                    done_nxt_s = 1'b1;
                end else begin
                    sync_n_nxt_s = 1'b0;
                    sclk_nxt_s   = div_end_s ? ~sclk_r : sclk_r;
                    sdata_nxt_s  = rise_s ? shift_r[14] : sdata_r;
                end
            end
            default: begin
                sclk_nxt_s = 1'b1;
            end
        endcase
    end

    // Output registers
    always_ff @(posedge clk) begin
        if (!rst) begin
            ready_r   <= 1'b0;
            dropped_r <= 1'b0;
            done_r    <= 1'b0;
            sclk_r    <= 1'b1;
            sync_n_r  <= 1'b1;
            sdata_r   <= 1'b0;
        end else begin
            ready_r   <= ready_nxt_s;
            dropped_r <= dropped_nxt_s;
            done_r    <= done_nxt_s;
            sclk_r    <= sclk_nxt_s;
            sync_n_r  <= sync_n_nxt_s;
            sdata_r   <= sdata_nxt_s;
        end
    end

    // Datapath: sample capture, shift register and timing counters
    always_ff @(posedge clk) begin
        if (!rst) begin
            code_r     <= 12'h000;
            shift_r    <= 15'h0000;
            div_cnt_r  <= 8'd0;
            half_cnt_r <= 5'd0;
            gap_cnt_r  <= 8'd0;
        end else begin
            if (accept_s) begin
                code_r <= code_s;
            end
            case (state_r)
                LOAD:    shift_r <= frame_s[14:0];
                SHIFT:   shift_r <= rise_s ? {shift_r[13:0], 1'b0} : shift_r;
                default: shift_r <= shift_r;
            endcase
            if ((state_r == SHIFT) && !div_end_s) begin
                div_cnt_r <= div_cnt_r + 8'd1;
            end else begin
                div_cnt_r <= 8'd0;
            end
            if (state_r != SHIFT) begin
                half_cnt_r <= 5'd0;
            end else if (div_end_s) begin
                half_cnt_r <= half_cnt_r + 5'd1;
            end
            if (state_r == GAP) begin
                gap_cnt_r <= gap_cnt_r + 8'd1;
            end else begin
                gap_cnt_r <= 8'd0;
            end
        end
    end

    assign ready   = ready_r;
    assign dropped = dropped_r;
    assign done    = done_r;
    assign sclk    = sclk_r;
    assign sync_n  = sync_n_r;
    assign sdata   = sdata_r;

endmodule

// File: tb/tb_dac_spi_driver.sv
// Bench for dac_spi_driver: table of samples with expected frames, scoreboarded against
// the bits captured on sclk falling edges, plus streaming, abort and CLK_DIV=1 sequences.
`ifndef DAC_MAX_V_BIT
`define DAC_MAX_V_BIT 13
`endif
`ifndef DAC_MAX_V
`define DAC_MAX_V 3300
`endif

module tb_dac_spi_driver;

    localparam int W = `DAC_MAX_V_BIT;

    logic         clk = 1'b0;
    logic         rst;
    logic [W-1:0] sample_in;
    logic         sample_valid, valid1;
    logic         ready, dropped, done, sclk, sync_n, sdata;
    logic         ready1, dropped1, done1, sclk1, sync_n1, sdata1;

    int           n_vec  = 0;
    int           n_miss = 0;
    logic [15:0]  sb[$];
    bit           mon_en = 1'b0;
    logic         prev_sclk = 1'b1;
    logic [15:0]  mon_bits = 16'h0000;
    int           mon_falls = 0;

    typedef struct {
        logic [W-1:0] sample;
        logic [15:0]  exp_scaled;
        logic [15:0]  exp_raw;
    } vec_t;

    always #5 clk = ~clk;

    dac_spi_driver #(.CLK_DIV(2), .GAP_CYCLES(2)) u_dut (
        .clk(clk), .rst(rst), .sample_in(sample_in), .sample_valid(sample_valid),
        .ready(ready), .dropped(dropped), .done(done),
        .sclk(sclk), .sync_n(sync_n), .sdata(sdata)
    );

    dac_spi_driver #(.CLK_DIV(1), .GAP_CYCLES(2)) u_dut1 (
        .clk(clk), .rst(rst), .sample_in(sample_in), .sample_valid(valid1),
        .ready(ready1), .dropped(dropped1), .done(done1),
        .sclk(sclk1), .sync_n(sync_n1), .sdata(sdata1)
    );

    function automatic logic [15:0] pick(input logic [15:0] scaled, input logic [15:0] raw);
`ifdef DAC_MV_SCALE_EN
        return scaled;
`else
        return raw;
`endif
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic timeout(input string name);
        n_vec++;
        n_miss++;
        $display("FAIL %s: timed out", name);
    endtask

    // Frame monitor: DAC-side capture on sclk falling edges, compared on each done pulse
    always @(negedge clk) begin
        if (mon_en) begin
            if (!sync_n && prev_sclk && !sclk) begin
                mon_bits = {mon_bits[14:0], sdata};
                mon_falls++;
            end
            if (done) begin
                if (sb.size() == 0) begin
                    timeout("sb_underflow");
                end else begin
                    check("frame", {16'h0, mon_bits}, {16'h0, sb.pop_front()});
                    check("fall_count", mon_falls, 16);
                end
                mon_falls = 0;
            end else if (sync_n) begin
                mon_falls = 0;
            end
        end
        prev_sclk = sclk;
    end

    task automatic wait_ready();
        bit got = 1'b0;
        for (int i = 0; i < 300 && !got; i++) begin
            if (ready) got = 1'b1;
            else @(negedge clk);
        end
        if (!got) timeout("wait_ready");
    endtask

    task automatic send(input logic [W-1:0] s, input logic [15:0] exp);
        int  n = 0;
        int  m = 0;
        bit  got = 1'b0;
        wait_ready();
        sample_in    = s;
        sample_valid = 1'b1;
        sb.push_back(exp);
        @(posedge clk);
        @(negedge clk);
        sample_valid = 1'b0;
        for (int i = 1; i <= 400 && !got; i++) begin
            @(negedge clk);
            if (done) begin
                got = 1'b1;
                n   = i;
            end
        end
        if (!got) timeout("done_wait");
        check("done_latency", n, 65);
        m   = n;
        got = 1'b0;
        for (int i = 0; i < 100 && !got; i++) begin
            @(negedge clk);
            m++;
            if (ready) got = 1'b1;
        end
        if (!got) timeout("ready_wait");
        check("ready_latency", m, 67);
    endtask

    initial begin
        vec_t vecs[9];
        int   drops, dones, starts_n;
        int   t_start[$];
        logic prev_sync;
        bit   got;

        vecs[0] = '{sample: W'(3300), exp_scaled: 16'h0FFF, exp_raw: 16'h0CE4};
        vecs[1] = '{sample: W'(1650), exp_scaled: 16'h07FF, exp_raw: 16'h0672};
        vecs[2] = '{sample: W'(0),    exp_scaled: 16'h0000, exp_raw: 16'h0000};
        vecs[3] = '{sample: W'(4000), exp_scaled: 16'h0FFF, exp_raw: 16'h0FA0};
        vecs[4] = '{sample: W'(4095), exp_scaled: 16'h0FFF, exp_raw: 16'h0FFF};
        vecs[5] = '{sample: W'(8191), exp_scaled: 16'h0FFF, exp_raw: 16'h0FFF};
        vecs[6] = '{sample: W'(825),  exp_scaled: 16'h03FF, exp_raw: 16'h0339};
        vecs[7] = '{sample: W'(1),    exp_scaled: 16'h0001, exp_raw: 16'h0001};
        vecs[8] = '{sample: W'(2730), exp_scaled: 16'h0D3B, exp_raw: 16'h0AAA};

        rst = 1'b0; sample_valid = 1'b0; valid1 = 1'b0; sample_in = '0;
        repeat (3) @(negedge clk);
        check("reset_outputs", {26'h0, sclk, sync_n, sdata, done, dropped, ready},
              {26'h0, 6'b110000});
        rst = 1'b1;
        @(negedge clk);
        check("ready_after_reset", ready, 1);
        mon_en = 1'b1;

        for (int i = 0; i < 9; i++) begin
            send(vecs[i].sample, pick(vecs[i].exp_scaled, vecs[i].exp_raw));
        end

        // Streaming: valid held for 200 cycles; accept cycle is an IDLE cycle on top of
        // the 67 busy cycles, so frame starts are 68 edges apart
        wait_ready();
        for (int i = 0; i < 3; i++) sb.push_back(pick(16'h09B1, 16'h07D0));
        sample_in = W'(2000);
        sample_valid = 1'b1;
        drops = 0; dones = 0; prev_sync = sync_n;
        for (int i = 0; i < 200; i++) begin
            @(posedge clk);
            @(negedge clk);
            if (dropped) drops++;
            if (done) dones++;
            if (prev_sync && !sync_n) t_start.push_back(i);
            prev_sync = sync_n;
        end
        sample_valid = 1'b0;
        got = 1'b0;
        for (int i = 0; i < 300 && !got; i++) begin
            @(negedge clk);
            if (dropped) drops++;
            if (done) dones++;
            if (prev_sync && !sync_n) t_start.push_back(200 + i);
            prev_sync = sync_n;
            if (ready) got = 1'b1;
        end
        if (!got) timeout("stream_drain");
        starts_n = t_start.size();
        check("stream_frames", starts_n, 3);
        check("stream_dones", dones, 3);
        check("stream_drops", drops, 197);
        if (starts_n == 3) begin
            check("stream_spacing0", t_start[1] - t_start[0], 68);
            check("stream_spacing1", t_start[2] - t_start[1], 68);
        end

        // Abort during bit 7: no done, lines return to idle immediately
        wait_ready();
        sample_in = W'(1365);
        sample_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        sample_valid = 1'b0;
        repeat (34) @(negedge clk);
        check("abort_precond_sync", sync_n, 0);
        rst = 1'b0;
        @(negedge clk);
        check("abort_outputs", {27'h0, sync_n, sclk, sdata, done, ready}, {27'h0, 5'b11000});
        rst = 1'b1;
        @(negedge clk);
        check("abort_ready", ready, 1);
        dones = 0;
        repeat (80) begin
            @(negedge clk);
            if (done) dones++;
        end
        check("abort_no_done", dones, 0);

        // CLK_DIV=1 instance
        begin
            int          low = 0, falls = 0, chg = 0, lat = 0, drops1 = 0;
            logic        p;
            logic [15:0] bits = 16'h0000;
            got = 1'b0;
            for (int i = 0; i < 50 && !got; i++) begin
                if (ready1) got = 1'b1;
                else @(negedge clk);
            end
            if (!got) timeout("div1_ready");
            sample_in = W'(3000);
            valid1 = 1'b1;
            @(posedge clk);
            @(negedge clk);
            valid1 = 1'b0;
            p   = sclk1;
            got = 1'b0;
            for (int i = 1; i <= 200 && !got; i++) begin
                @(negedge clk);
                if (dropped1) drops1++;
                if (!sync_n1) begin
                    low++;
                    if (p && !sclk1) begin
                        falls++;
                        bits = {bits[14:0], sdata1};
                    end
                    if (sclk1 != p) chg++;
                end
                p = sclk1;
                if (done1) begin
                    got = 1'b1;
                    lat = i;
                end
            end
            if (!got) timeout("div1_done");
            check("div1_shift_len", low, 32);
            check("div1_falls", falls, 16);
            check("div1_toggles", chg, 31);
            check("div1_done_latency", lat, 33);
            check("div1_frame", {16'h0, bits}, {16'h0, pick(16'h0E8A, 16'h0BB8)});
            check("div1_no_drop", drops1, 0);
        end

        check("sb_leftover", sb.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
